// File: rtl/game_controller_pkg.sv
// -----------------------------------------------------------------------------
// game_controller_pkg
// Shared definitions for the Pong rally sequencer: state encodings (these
// values are also shown on o_State), default frame constants, the score width
// and a saturating score increment.
// Ports: none (package).
// -----------------------------------------------------------------------------
package game_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int SCORE_W          = 4;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_POINT_FRAMES = 90;
    localparam int DEF_WIN_SCORE    = 9;
    localparam int DEF_BLINK_LOG2   = 5;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Scores stick at the top value instead of wrapping back to zero.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/game_controller_if.sv
// -----------------------------------------------------------------------------
// game_controller_if
// Bundles the rally controller's strobes and video-layer controls.
// master: the frame/ball side that raises strobes and consumes the controls.
// slave : the controller itself.
// Signals:
//   i_Frame          once-per-frame strobe (start of vertical blank)
//   i_Start          start/restart request level
//   i_Miss_L/i_Miss_R ball passed the left/right edge (one-cycle strobes)
//   o_Ball_En, o_Ball_Reset, o_Serve_Dir, o_Net_En  layer controls
//   o_Score_L, o_Score_R, o_Winner, o_State         game status
// -----------------------------------------------------------------------------
interface game_controller_if;
    import game_controller_pkg::*;

    logic               i_Frame;
    logic               i_Start;
    logic               i_Miss_L;
    logic               i_Miss_R;
    logic               o_Ball_En;
    logic               o_Ball_Reset;
    logic               o_Serve_Dir;
    logic               o_Net_En;
    logic [SCORE_W-1:0] o_Score_L;
    logic [SCORE_W-1:0] o_Score_R;
    logic               o_Winner;
    logic [2:0]         o_State;

    modport master (
        output i_Frame, i_Start, i_Miss_L, i_Miss_R,
        input  o_Ball_En, o_Ball_Reset, o_Serve_Dir, o_Net_En,
        input  o_Score_L, o_Score_R, o_Winner, o_State
    );

    modport slave (
        input  i_Frame, i_Start, i_Miss_L, i_Miss_R,
        output o_Ball_En, o_Ball_Reset, o_Serve_Dir, o_Net_En,
        output o_Score_L, o_Score_R, o_Winner, o_State
    );

endinterface

// File: rtl/game_controller_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Counts frame strobes within one controller state.
// Ports:
//   i_Clk    clock
//   i_Reset  synchronous active-high reset
//   i_Clear  high in the first cycle of a new state; discards the old count
//   i_Frame  frame strobe
//   i_Limit  number of strobes that completes the current state
//   o_Done   pulses on the strobe that brings the count to i_Limit
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int WIDTH = 7
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Clear,
    input  logic        i_Frame,
    input  logic [15:0] i_Limit,
    output logic        o_Done
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] count_next;

    // The clear acts in the entry cycle itself, so a strobe landing there
    // already counts as the new state's first frame.
    assign base       = i_Clear ? '0 : count;
    assign count_next = base + WIDTH'(i_Frame);

    // Combinational so the controller can leave on the very edge that ends
    // the strobe cycle.
    assign o_Done = i_Frame && (16'(count_next) == i_Limit);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
// Rally sequencer for Pong: IDLE -> SERVE -> PLAY -> POINT/GAME_OVER. It keeps
// both scores, chooses the serve direction and gates the ball and net layers.
// Every output is a flop that changes on the edge after its trigger.
// Ports:
//   i_Clk    pixel clock
//   i_Reset  synchronous active-high reset
//   ctrl     game_controller_if.slave (strobes in, layer controls/scores out)
// -----------------------------------------------------------------------------
module game_controller
    import game_controller_pkg::*;
#(
    parameter int p_SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int p_POINT_FRAMES = DEF_POINT_FRAMES,
    parameter int p_WIN_SCORE    = DEF_WIN_SCORE,
    parameter int p_BLINK_LOG2   = DEF_BLINK_LOG2
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    game_controller_if.slave  ctrl
);

    localparam int TIMER_W = $clog2(((p_SERVE_FRAMES > p_POINT_FRAMES) ?
                                     p_SERVE_FRAMES : p_POINT_FRAMES) + 1);
    localparam int BLINK_W = p_BLINK_LOG2 + 1;
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(p_WIN_SCORE);

    state_t             state;
    logic               ball_en;
    logic               ball_reset;
    logic               serve_dir;
    logic               net_en;
    logic               winner;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [SCORE_W-1:0] score_l_inc;
    logic [SCORE_W-1:0] score_r_inc;
    logic               timer_clear;
    logic               timer_done;
    logic [15:0]        timer_limit;
    logic [BLINK_W-1:0] blink;
    logic [BLINK_W-1:0] blink_next;

    // One timer serves both timed states; only the limit changes.
    assign timer_limit = (state == ST_SERVE) ? 16'(p_SERVE_FRAMES) : 16'(p_POINT_FRAMES);

    frame_timer #(.WIDTH(TIMER_W)) timer (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Clear (timer_clear),
        .i_Frame (ctrl.i_Frame),
        .i_Limit (timer_limit),
        .o_Done  (timer_done)
    );

    assign score_l_inc = score_inc(score_l);
    assign score_r_inc = score_inc(score_r);
    assign blink_next  = blink + BLINK_W'(ctrl.i_Frame);

    // Single sequencer: each branch that changes state also sets the
    // registered layer controls for the state being entered. timer_clear is
    // raised for exactly the first cycle of every new state.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            ball_en     <= 1'b0;
            ball_reset  <= 1'b1;
            serve_dir   <= 1'b0;
            net_en      <= 1'b1;
            winner      <= 1'b0;
            score_l     <= '0;
            score_r     <= '0;
            timer_clear <= 1'b0;
            blink       <= '0;
        end else begin
            timer_clear <= 1'b0;
            blink       <= blink_next;
            net_en      <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (ctrl.i_Start) begin
                        state       <= ST_SERVE;
                        timer_clear <= 1'b1;
                        score_l     <= '0;
                        score_r     <= '0;
                    end
                end
                ST_SERVE: begin
                    if (timer_done) begin
                        state       <= ST_PLAY;
                        timer_clear <= 1'b1;
                        ball_en     <= 1'b1;
                        ball_reset  <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (ctrl.i_Miss_L || ctrl.i_Miss_R) begin
                        timer_clear <= 1'b1;
                        ball_en     <= 1'b0;
                        ball_reset  <= 1'b1;
                    end
                    // A double miss is a dead rally: nobody scores, re-serve.
                    if (ctrl.i_Miss_L && ctrl.i_Miss_R) begin
                        state <= ST_SERVE;
                    end else if (ctrl.i_Miss_L) begin
                        score_r   <= score_r_inc;
                        serve_dir <= 1'b0;
                        if (score_r_inc == WIN) begin
                            state  <= ST_GAME_OVER;
                            winner <= 1'b1;
                            blink  <= '0;
                        end else begin
                            state <= ST_POINT;
                        end
                    end else if (ctrl.i_Miss_R) begin
                        score_l   <= score_l_inc;
                        serve_dir <= 1'b1;
                        if (score_l_inc == WIN) begin
                            state  <= ST_GAME_OVER;
                            winner <= 1'b0;
                            blink  <= '0;
                        end else begin
                            state <= ST_POINT;
                        end
                    end
                end
                ST_POINT: begin
                    if (timer_done) begin
                        state       <= ST_SERVE;
                        timer_clear <= 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    if (ctrl.i_Start) begin
                        state       <= ST_SERVE;
                        timer_clear <= 1'b1;
                        score_l     <= '0;
                        score_r     <= '0;
                        serve_dir   <= 1'b0;
                    end else begin
                        // Blink counter restarts on entry, so the net starts lit.
                        net_en <= ~blink_next[p_BLINK_LOG2];
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ball_en    <= 1'b0;
                    ball_reset <= 1'b1;
                end
            endcase
        end
    end

    assign ctrl.o_State      = state;
    assign ctrl.o_Ball_En    = ball_en;
    assign ctrl.o_Ball_Reset = ball_reset;
    assign ctrl.o_Serve_Dir  = serve_dir;
    assign ctrl.o_Net_En     = net_en;
    assign ctrl.o_Score_L    = score_l;
    assign ctrl.o_Score_R    = score_r;
    assign ctrl.o_Winner     = winner;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
// Self-checking bench for game_controller with short frame constants.
// A game-level model (phase, frames seen in the phase, scores) predicts every
// output after each clock; directed rallies are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_game_controller;

    localparam int SERVE_F = 3;
    localparam int POINT_F = 2;
    localparam int WIN     = 3;
    localparam int BLINK_L = 1;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_POINT = 3;
    localparam int M_OVER  = 4;

    logic i_Clk   = 1'b0;
    logic i_Reset = 1'b1;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    int m_state, m_frames, m_blink, m_score_l, m_score_r, m_dir, m_winner;

    game_controller_if ctrl();

    game_controller #(
        .p_SERVE_FRAMES (SERVE_F),
        .p_POINT_FRAMES (POINT_F),
        .p_WIN_SCORE    (WIN),
        .p_BLINK_LOG2   (BLINK_L)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .ctrl    (ctrl.slave)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", phase, tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_state   = M_IDLE;
        m_frames  = 0;
        m_blink   = 0;
        m_score_l = 0;
        m_score_r = 0;
        m_dir     = 0;
        m_winner  = 0;
    endtask

    // Game rules applied to one cycle of inputs.
    task automatic modelStep(input bit f, input bit s, input bit ml, input bit mr, input bit r);
        int prev;
        if (r) begin
            modelReset();
            return;
        end
        prev = m_state;
        case (m_state)
            M_IDLE: if (s) begin
                m_state = M_SERVE; m_score_l = 0; m_score_r = 0;
            end
            M_SERVE: if (f) begin
                m_frames++;
                if (m_frames == SERVE_F) m_state = M_PLAY;
            end
            M_PLAY: begin
                if (ml && mr) m_state = M_SERVE;
                else if (ml) begin
                    m_score_r = (m_score_r < 15) ? m_score_r + 1 : 15;
                    m_dir = 0;
                    if (m_score_r == WIN) begin m_state = M_OVER; m_winner = 1; end
                    else m_state = M_POINT;
                end else if (mr) begin
                    m_score_l = (m_score_l < 15) ? m_score_l + 1 : 15;
                    m_dir = 1;
                    if (m_score_l == WIN) begin m_state = M_OVER; m_winner = 0; end
                    else m_state = M_POINT;
                end
            end
            M_POINT: if (f) begin
                m_frames++;
                if (m_frames == POINT_F) m_state = M_SERVE;
            end
            M_OVER: begin
                if (s) begin
                    m_state = M_SERVE; m_score_l = 0; m_score_r = 0; m_dir = 0;
                end else if (f) begin
                    m_blink++;
                end
            end
            default: ;
        endcase
        if (m_state != prev) begin
            m_frames = 0;
            m_blink  = 0;
        end
    endtask

    task automatic compareAll();
        int exp_net;
        exp_net = (m_state == M_OVER) ? int'(((m_blink / (2 ** BLINK_L)) % 2) == 0) : 1;
        checkOutput("state", int'(ctrl.o_State), m_state);
        checkOutput("ball_en", int'(ctrl.o_Ball_En), int'(m_state == M_PLAY));
        checkOutput("ball_reset", int'(ctrl.o_Ball_Reset), int'(m_state != M_PLAY));
        checkOutput("serve_dir", int'(ctrl.o_Serve_Dir), m_dir);
        checkOutput("net_en", int'(ctrl.o_Net_En), exp_net);
        checkOutput("score_l", int'(ctrl.o_Score_L), m_score_l);
        checkOutput("score_r", int'(ctrl.o_Score_R), m_score_r);
        if (m_state == M_OVER) checkOutput("winner", int'(ctrl.o_Winner), m_winner);
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic applyStimulus(input bit f, input bit s, input bit ml, input bit mr, input bit r);
        ctrl.i_Frame  = f;
        ctrl.i_Start  = s;
        ctrl.i_Miss_L = ml;
        ctrl.i_Miss_R = mr;
        i_Reset       = r;
        @(posedge i_Clk);
        #1;
        modelStep(f, s, ml, mr, r);
        ctrl.i_Frame  = 1'b0;
        ctrl.i_Start  = 1'b0;
        ctrl.i_Miss_L = 1'b0;
        ctrl.i_Miss_R = 1'b0;
        i_Reset       = 1'b0;
        compareAll();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            applyStimulus(1, 0, 0, 0, 0);
            idle(1);
        end
    endtask

    initial begin
        ctrl.i_Frame  = 1'b0;
        ctrl.i_Start  = 1'b0;
        ctrl.i_Miss_L = 1'b0;
        ctrl.i_Miss_R = 1'b0;
        modelReset();

        phase = "reset";
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("state_is_idle", int'(ctrl.o_State), 0);
        checkOutput("ball_reset_high", int'(ctrl.o_Ball_Reset), 1);
        idle(2);

        phase = "start";
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("in_serve", int'(ctrl.o_State), 1);
        frames(2);
        checkOutput("still_serve", int'(ctrl.o_State), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("in_play", int'(ctrl.o_State), 2);
        checkOutput("ball_moving", int'(ctrl.o_Ball_En), 1);

        phase = "point";
        idle(3);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("score_l_one", int'(ctrl.o_Score_L), 1);
        checkOutput("dir_right", int'(ctrl.o_Serve_Dir), 1);
        checkOutput("in_point", int'(ctrl.o_State), 3);
        frames(POINT_F);
        checkOutput("back_to_serve", int'(ctrl.o_State), 1);
        frames(SERVE_F);

        phase = "win";
        for (int k = 0; k < WIN; k++) begin
            idle(2);
            applyStimulus(0, 0, 1, 0, 0);
            if (m_state == M_POINT) begin
                frames(POINT_F);
                frames(SERVE_F);
            end
        end
        checkOutput("score_r_win", int'(ctrl.o_Score_R), 3);
        checkOutput("in_game_over", int'(ctrl.o_State), 4);
        checkOutput("right_won", int'(ctrl.o_Winner), 1);
        frames(8);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("restart_state", int'(ctrl.o_State), 1);
        checkOutput("restart_score_r", int'(ctrl.o_Score_R), 0);
        checkOutput("restart_dir", int'(ctrl.o_Serve_Dir), 0);

        phase = "double_miss";
        frames(SERVE_F);
        idle(1);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("dead_rally_serve", int'(ctrl.o_State), 1);

        phase = "ignored";
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("miss_in_serve", int'(ctrl.o_Score_R), 0);
        frames(SERVE_F);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("start_in_play", int'(ctrl.o_State), 2);

        phase = "mid_reset";
        applyStimulus(0, 0, 0, 1, 0);
        frames(POINT_F);
        frames(SERVE_F);
        applyStimulus(0, 0, 0, 1, 0);
        frames(POINT_F);
        frames(SERVE_F);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("score_2_1", int'(ctrl.o_Score_L) * 16 + int'(ctrl.o_Score_R), 2 * 16 + 1);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("reset_idle", int'(ctrl.o_State), 0);
        checkOutput("reset_net", int'(ctrl.o_Net_En), 1);

        phase = "random";
        repeat (3000) begin
            applyStimulus($urandom_range(0, 2) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
